// File: rtl/frame_serializer.sv
// Byte-FIFO-fed frame serializer: store-and-forward frames of sync header + payload bits, MSB first.
// Optional CRC8 trailer (poly 0x07) is enabled by defining FRAME_CRC_EN.
//
// state   | meaning
// IDLE    | waiting for a full frame of payload in the FIFO
// HEADER  | shifting out the sync header
// PAYLOAD | shifting out payload bytes, popping one per byte
// CRC     | shifting out the CRC8 trailer (FRAME_CRC_EN only)
// GAP     | valid held low between frames
module frame_serializer #(
  parameter int             HEADER_LEN     = 7,
  parameter logic [HEADER_LEN-1:0] HEADER_PATTERN = 7'b1110010,
  parameter int             PAYLOAD_BYTES  = 16,
  parameter int             FIFO_DEPTH     = 32,
  parameter int             GAP_CYCLES     = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [7:0]                      s_data,
  input  logic                            s_valid,
  output logic                            s_ready,
  output logic                            o_bit_valid,
  output logic                            o_bit_data,
  output logic                            o_frame_start,
  output logic                            o_busy,
  output logic [$clog2(FIFO_DEPTH):0]     o_fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = (HEADER_LEN > 8) ? HEADER_LEN : 8;
  localparam int BW = $clog2(SW);
  localparam int NW = $clog2(PAYLOAD_BYTES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_CRC,
    ST_GAP
  } state_t;

  state_t state, next_state;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    head;
  logic          wr, pop, start;

  logic [SW-1:0] shreg;
  logic [BW-1:0] bit_idx;
  logic [NW-1:0] byte_cnt;
  logic [GW-1:0] gap_cnt;
  logic          last_byte;

`ifdef FRAME_CRC_EN
  logic [7:0] crc;

  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++)
      r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    return r;
  endfunction
`endif

  // FIFO
  assign s_ready      = !rst && (count != CW'(FIFO_DEPTH));
  assign wr           = s_valid && s_ready;
  assign head         = mem[rd_ptr];
  assign o_fifo_count = count;

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FSM
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  assign last_byte = (byte_cnt == NW'(PAYLOAD_BYTES - 1));

  always_comb begin
    next_state    = state;
    pop           = 1'b0;
    start         = 1'b0;
    o_bit_valid   = 1'b0;
    o_frame_start = 1'b0;
    o_busy        = 1'b1;
    case (state)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (count >= CW'(PAYLOAD_BYTES)) begin
          start      = 1'b1;
          next_state = ST_HEADER;
        end
      end
      ST_HEADER: begin
        o_bit_valid   = 1'b1;
        o_frame_start = (bit_idx == BW'(HEADER_LEN - 1));
        if (bit_idx == '0) begin
          pop        = 1'b1;
          next_state = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        o_bit_valid = 1'b1;
        if (bit_idx == '0) begin
          if (!last_byte) pop = 1'b1;
`ifdef FRAME_CRC_EN
          else next_state = ST_CRC;
`else
          else next_state = ST_GAP;
`endif
        end
      end
`ifdef FRAME_CRC_EN
      ST_CRC: begin
        o_bit_valid = 1'b1;
        if (bit_idx == '0) next_state = ST_GAP;
      end
`endif
      ST_GAP: begin
        if (gap_cnt == '0) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign o_bit_data = o_bit_valid & shreg[SW-1];

  // Datapath: one shift register carries header, payload and CRC bits
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      bit_idx  <= '0;
      byte_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      if (start) begin
        shreg    <= SW'(HEADER_PATTERN) << (SW - HEADER_LEN);
        bit_idx  <= BW'(HEADER_LEN - 1);
        byte_cnt <= '0;
      end else if (o_bit_valid) begin
        if (pop) begin
          shreg   <= SW'(head) << (SW - 8);
          bit_idx <= BW'(7);
          if (state == ST_PAYLOAD) byte_cnt <= byte_cnt + 1'b1;
`ifdef FRAME_CRC_EN
        end else if (state == ST_PAYLOAD && bit_idx == '0) begin
          shreg   <= SW'(crc) << (SW - 8);
          bit_idx <= BW'(7);
`endif
        end else begin
          shreg   <= {shreg[SW-2:0], 1'b0};
          bit_idx <= bit_idx - 1'b1;
        end
      end
      if (next_state == ST_GAP && state != ST_GAP) gap_cnt <= GW'(GAP_CYCLES - 1);
      else if (state == ST_GAP && gap_cnt != '0)   gap_cnt <= gap_cnt - 1'b1;
    end
  end

`ifdef FRAME_CRC_EN
  always_ff @(posedge clk) begin
    if (rst)        crc <= '0;
    else if (start) crc <= '0;
    else if (pop)   crc <= crc8_byte(crc, head);
  end
`endif

endmodule

// File: tb/tb_frame_serializer.sv
// Directed + randomized bench for frame_serializer (PAYLOAD_BYTES=2, FIFO_DEPTH=4, GAP_CYCLES=4).
// Outputs are logged every negedge; frames are rebuilt from the log and compared to a byte-level model.
module tb_frame_serializer;

  localparam int HL    = 7;
  localparam logic [6:0] HP = 7'b1110010;
  localparam int PB    = 2;
  localparam int DEPTH = 4;
  localparam int GAP   = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef FRAME_CRC_EN
  localparam int CRC_BITS = 8;
`else
  localparam int CRC_BITS = 0;
`endif
  localparam int FLEN  = HL + 8 * PB + CRC_BITS;
  localparam int TMAX  = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready, o_bit_valid, o_bit_data, o_frame_start, o_busy;
  logic [CW-1:0] o_fifo_count;

  frame_serializer #(
    .HEADER_LEN(HL), .HEADER_PATTERN(HP), .PAYLOAD_BYTES(PB),
    .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .o_bit_valid(o_bit_valid), .o_bit_data(o_bit_data), .o_frame_start(o_frame_start),
    .o_busy(o_busy), .o_fifo_count(o_fifo_count)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  logic tv [TMAX];
  logic td [TMAX];
  logic ts [TMAX];
  int   tc [TMAX];
  int   cyc = 0;

  always @(negedge clk) begin
    if (cyc < TMAX) begin
      tv[cyc] = o_bit_valid;
      td[cyc] = o_bit_data;
      ts[cyc] = o_frame_start;
      tc[cyc] = int'(o_fifo_count);
      cyc++;
    end
  end

  logic [63:0] f_val[$];
  int          f_len[$];
  int          f_st[$];
  int          f_fsbad[$];
  int          idle_bad;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    s_valid = 1'b1;
    s_data  = b;
    step();
    s_valid = 1'b0;
  endtask

  // Rebuild frames (maximal runs of valid) from the log window [from, to)
  task automatic extract(input int from, input int to);
    int i;
    f_val.delete(); f_len.delete(); f_st.delete(); f_fsbad.delete();
    idle_bad = 0;
    i = from;
    while (i < to) begin
      if (tv[i]) begin
        logic [63:0] v;
        int n, fsb, st;
        v = '0; n = 0; fsb = 0; st = i;
        while (i < to && tv[i]) begin
          v = {v[62:0], td[i]};
          if (ts[i] !== (n == 0)) fsb++;
          n++; i++;
        end
        f_val.push_back(v); f_len.push_back(n); f_st.push_back(st); f_fsbad.push_back(fsb);
      end else begin
        if (td[i] !== 1'b0 || ts[i] !== 1'b0) idle_bad++;
        i++;
      end
    end
  endtask

  // Reference: header, then payload bytes, then CRC8 computed by bitwise long division
  function automatic logic [63:0] exp_frame(input logic [7:0] b0, input logic [7:0] b1);
    logic [63:0] v;
    logic [7:0]  msg [2];
    logic [7:0]  c;
    logic        fb;
    msg[0] = b0; msg[1] = b1;
    v = 64'(HP);
    c = '0;
    for (int k = 0; k < PB; k++) begin
      v = (v << 8) | 64'(msg[k]);
      for (int j = 7; j >= 0; j--) begin
        fb = c[7] ^ msg[k][j];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    if (CRC_BITS != 0) v = (v << 8) | 64'(c);
    return v;
  endfunction

  initial begin
    int t0, w, st;
    logic [7:0] b [4];
    logic [7:0] r0, r1;

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    check("rst_valid", o_bit_valid, 0);
    check("rst_data", o_bit_data, 0);
    check("rst_fs", o_frame_start, 0);
    check("rst_busy", o_busy, 0);
    check("rst_ready", s_ready, 0);
    check("rst_count", o_fifo_count, 0);
    rst = 1'b0;
    step();
    check("ready_after_rst", s_ready, 1);

    // Known vector A5, 3C
    t0 = cyc;
    push(8'hA5); push(8'h3C);
    repeat (60) step();
    extract(t0, cyc);
    check("t1_nframes", f_val.size(), 1);
    if (f_val.size() == 1) begin
      st = f_st[0];
      check("t1_len", f_len[0], FLEN);
      check("t1_bits", f_val[0], exp_frame(8'hA5, 8'h3C));
`ifdef FRAME_CRC_EN
      check("t1_crc", f_val[0][7:0], 8'hED);
`endif
      check("t1_fs", f_fsbad[0], 0);
      check("t1_lat_cnt2", tc[st-1], 2);
      check("t1_lat_cnt1", tc[st-2], 1);
      check("t1_trail_gap", (cyc - (st + f_len[0])) >= GAP + 1, 1);
    end
    check("t1_idle_zero", idle_bad, 0);
    check("t1_count_end", o_fifo_count, 0);

    // Partial payload then completion
    t0 = cyc;
    push(8'h11);
    repeat (100) step();
    extract(t0, cyc);
    check("t2_no_frame", f_val.size(), 0);
    check("t2_count1", o_fifo_count, 1);
    t0 = cyc;
    push(8'h22);
    repeat (60) step();
    extract(t0 - 2, cyc);
    check("t2_nframes", f_val.size(), 1);
    if (f_val.size() == 1) begin
      st = f_st[0];
      check("t2_bits", f_val[0], exp_frame(8'h11, 8'h22));
      check("t2_lat_cnt2", tc[st-1], 2);
      check("t2_lat_cnt1", tc[st-2], 1);
    end

    // FIFO full, ignored extra write, back-to-back frames
    for (int k = 0; k < 4; k++) b[k] = 8'($urandom);
    t0 = cyc;
    for (int k = 0; k < 4; k++) push(b[k]);
    check("t3_full_ready", s_ready, 0);
    check("t3_full_count", o_fifo_count, 4);
    s_valid = 1'b1;
    s_data  = 8'($urandom);
    step();
    s_valid = 1'b0;
    check("t3_ignored_count", o_fifo_count, 4);
    repeat (120) step();
    extract(t0, cyc);
    check("t3_nframes", f_val.size(), 2);
    if (f_val.size() == 2) begin
      check("t3_bits0", f_val[0], exp_frame(b[0], b[1]));
      check("t3_bits1", f_val[1], exp_frame(b[2], b[3]));
      check("t3_len1", f_len[1], FLEN);
      check("t3_spacing", f_st[1] - (f_st[0] + f_len[0]), GAP + 1);
      check("t3_fs1", f_fsbad[1], 0);
    end
    check("t3_idle_zero", idle_bad, 0);
    check("t3_count_end", o_fifo_count, 0);

    // Randomized bytes with random spacing between writes
    for (int it = 0; it < 4; it++) begin
      r0 = 8'($urandom);
      r1 = 8'($urandom);
      t0 = cyc;
      push(r0);
      repeat ($urandom_range(0, 5)) step();
      push(r1);
      repeat (60) step();
      extract(t0, cyc);
      check("t4_nframes", f_val.size(), 1);
      if (f_val.size() == 1) check("t4_bits", f_val[0], exp_frame(r0, r1));
    end

    // Reset in the middle of a frame
    push(8'($urandom)); push(8'($urandom)); push(8'($urandom));
    w = 0;
    while (!o_bit_valid && w < 20) begin step(); w++; end
    check("t5_started", o_bit_valid, 1);
    repeat (9) step();
    rst = 1'b1;
    step();
    check("t5_valid_drop", o_bit_valid, 0);
    check("t5_flush", o_fifo_count, 0);
    check("t5_busy", o_busy, 0);
    rst = 1'b0;
    step();
    check("t5_ready", s_ready, 1);
    t0 = cyc;
    repeat (60) step();
    extract(t0, cyc);
    check("t5_no_frame", f_val.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
